// File: rtl/pe_row_pixel_feeder.sv
// Packs a serial pixel stream into LANES-wide vectors plus a CAST-lane side vector for a PE row.
// Two storage levels (staging, output register); one input bubble per vector while staging hands off.
module pe_row_pixel_feeder #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int CAST  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] pixel [LANES-1:0],
  output logic [DW-1:0] pixel_cast [CAST-1:0],
  output logic          frame_done
);

  localparam int CW = $clog2(LANES);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] lane_cnt;
  logic [DW-1:0] staging [LANES-1:0];
  logic [DW-1:0] carry [CAST-1:0];
  logic [DW-1:0] cast_nx [CAST-1:0];
  logic [1:0]    mode_q;
  logic          first_of_frame;
  logic          last_stage;
  logic          last_out;
  logic          accept;
  logic          xfer;
  logic          lane_end;

  assign in_ready   = (state == FILL);
  assign accept     = in_valid & in_ready;
  assign xfer       = (state == FULL) & (~out_valid | out_ready);
  assign lane_end   = (lane_cnt == CW'(LANES - 1));
  assign frame_done = out_valid & out_ready & last_out;

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (accept && (lane_end || in_last)) state_nx = FULL;
      FULL:    if (xfer) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Overlap mode reuses the previous vector's tail; broadcast repeats the head of this one.
  always_comb begin
    for (int k = 0; k < CAST; k++) begin
      cast_nx[k] = '0;
      case (mode_q)
        2'd1:    cast_nx[k] = carry[k];
        2'd2:    cast_nx[k] = staging[k];
        default: cast_nx[k] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      lane_cnt       <= '0;
      mode_q         <= '0;
      first_of_frame <= 1'b1;
      last_stage     <= 1'b0;
      last_out       <= 1'b0;
      out_valid      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        staging[i] <= '0;
        pixel[i]   <= '0;
      end
      for (int k = 0; k < CAST; k++) begin
        carry[k]      <= '0;
        pixel_cast[k] <= '0;
      end
    end else begin
      state <= state_nx;

      if (accept) begin
        staging[lane_cnt] <= in_data;
        first_of_frame    <= in_last;
        if (lane_cnt == '0 && first_of_frame) mode_q <= mode;
        if (in_last) begin
          last_stage <= 1'b1;
          lane_cnt   <= '0;
        end else if (lane_end) begin
          lane_cnt <= '0;
        end else begin
          lane_cnt <= lane_cnt + CW'(1);
        end
      end

      if (xfer) begin
        out_valid  <= 1'b1;
        last_out   <= last_stage;
        last_stage <= 1'b0;
        for (int i = 0; i < LANES; i++) begin
          pixel[i]   <= staging[i];
          staging[i] <= '0;
        end
        for (int k = 0; k < CAST; k++) begin
          pixel_cast[k] <= cast_nx[k];
          carry[k]      <= last_stage ? '0 : staging[LANES-CAST+k];
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_row_pixel_feeder.sv
// Directed bench for pe_row_pixel_feeder: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_pe_row_pixel_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pixel [15:0];
  logic [7:0] pixel_cast [2:0];
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  logic [127:0] q_pix [$];
  logic [23:0]  q_cast [$];
  logic         q_fd [$];

  pe_row_pixel_feeder dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .pixel(pixel), .pixel_cast(pixel_cast), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pix_now();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = pixel[i];
    return v;
  endfunction

  function automatic logic [23:0] cast_now();
    logic [23:0] v;
    for (int k = 0; k < 3; k++) v[k*8 +: 8] = pixel_cast[k];
    return v;
  endfunction

  // Expected vector: lanes 0..n-1 = base+i*step, rest zero.
  function automatic logic [127:0] ramp(int base, int step, int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = 8'(base + i*step);
    return v;
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_pix.push_back(pix_now());
      q_cast.push_back(cast_now());
      q_fd.push_back(frame_done);
    end
  end

  task automatic clear_q();
    q_pix.delete(); q_cast.delete(); q_fd.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    int   budget;
    in_valid = 1'b1; in_data = d; in_last = l;
    acc = 1'b0; budget = 0;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      budget++;
      if (budget > 200) begin
        $display("FAIL send_timeout in_ready stuck low, got=%0b want=1", in_ready);
        failures++; checks++;
        acc = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_vectors(input int n);
    int budget;
    budget = 0;
    while (q_pix.size() < n && budget < 300) begin
      @(posedge clk); #1; budget++;
    end
    checks++;
    if (q_pix.size() !== n) begin
      $display("FAIL vector_count got=%0d want=%0d", q_pix.size(), n);
      failures++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idle(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'd0; out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b want=0", out_valid); failures++; end
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%0b want=1", in_ready); failures++; end
    if (frame_done !== 1'b0) begin $display("FAIL reset_frame_done got=%0b want=0", frame_done); failures++; end
    if (pix_now() !== 128'd0) begin $display("FAIL reset_pixel got=%h want=0", pix_now()); failures++; end
    if (cast_now() !== 24'd0) begin $display("FAIL reset_cast got=%h want=0", cast_now()); failures++; end
    @(posedge clk); #1;
  endtask

  task automatic test_mode0();
    mode = 2'd0; out_ready = 1'b1; clear_q();
    for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin $display("FAIL m0_latency_t1 out_valid got=%0b want=0", out_valid); failures++; end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin $display("FAIL m0_latency_t2 out_valid got=%0b want=1", out_valid); failures++; end
    @(posedge clk); #1;
    idle(5);
    wait_vectors(1);
    if (q_pix.size() == 1) begin
      checks += 3;
      if (q_pix[0] !== ramp(1, 1, 16)) begin $display("FAIL m0_pixel got=%h want=%h", q_pix[0], ramp(1, 1, 16)); failures++; end
      if (q_cast[0] !== 24'd0) begin $display("FAIL m0_cast got=%h want=0", q_cast[0]); failures++; end
      if (q_fd[0] !== 1'b1) begin $display("FAIL m0_frame_done got=%0b want=1", q_fd[0]); failures++; end
    end
  endtask

  task automatic test_mode1();
    logic [127:0] ep [3];
    logic [23:0]  ec [3];
    logic         ef [3];
    mode = 2'd1; out_ready = 1'b1; clear_q();
    for (int i = 1; i <= 32; i++) send(8'(i), i == 32);
    for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
    idle(5);
    ep[0] = ramp(1, 1, 16);  ec[0] = 24'd0;                ef[0] = 1'b0;
    ep[1] = ramp(17, 1, 16); ec[1] = {8'd16, 8'd15, 8'd14}; ef[1] = 1'b1;
    ep[2] = ramp(1, 1, 16);  ec[2] = 24'd0;                ef[2] = 1'b1;
    wait_vectors(3);
    for (int v = 0; v < 3 && v < q_pix.size(); v++) begin
      checks += 3;
      if (q_pix[v] !== ep[v]) begin $display("FAIL m1_pixel[%0d] got=%h want=%h", v, q_pix[v], ep[v]); failures++; end
      if (q_cast[v] !== ec[v]) begin $display("FAIL m1_cast[%0d] got=%h want=%h", v, q_cast[v], ec[v]); failures++; end
      if (q_fd[v] !== ef[v]) begin $display("FAIL m1_frame_done[%0d] got=%0b want=%0b", v, q_fd[v], ef[v]); failures++; end
    end
  endtask

  task automatic test_mode2_short();
    mode = 2'd2; out_ready = 1'b1; clear_q();
    for (int i = 1; i <= 5; i++) begin
      send(8'(i*10), i == 5);
      if (i == 2) idle(4);
    end
    idle(5);
    wait_vectors(1);
    if (q_pix.size() == 1) begin
      checks += 3;
      if (q_pix[0] !== ramp(10, 10, 5)) begin $display("FAIL m2_pixel got=%h want=%h", q_pix[0], ramp(10, 10, 5)); failures++; end
      if (q_cast[0] !== {8'd30, 8'd20, 8'd10}) begin $display("FAIL m2_cast got=%h want=1e140a", q_cast[0]); failures++; end
      if (q_fd[0] !== 1'b1) begin $display("FAIL m2_frame_done got=%0b want=1", q_fd[0]); failures++; end
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'd0; out_ready = 1'b0; clear_q();
    for (int i = 1; i <= 32; i++) send(8'(i), 1'b0);
    idle(2);
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready got=%0b want=0", in_ready); failures++; end
    if (out_valid !== 1'b1) begin $display("FAIL bp_out_valid got=%0b want=1", out_valid); failures++; end
    if (pix_now() !== ramp(1, 1, 16)) begin $display("FAIL bp_hold_pixel got=%h want=%h", pix_now(), ramp(1, 1, 16)); failures++; end
    repeat (6) @(negedge clk);
    checks++;
    if (pix_now() !== ramp(1, 1, 16)) begin $display("FAIL bp_stable_pixel got=%h want=%h", pix_now(), ramp(1, 1, 16)); failures++; end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 33; i <= 48; i++) send(8'(i), i == 48);
    idle(6);
    wait_vectors(3);
    for (int v = 0; v < 3 && v < q_pix.size(); v++) begin
      checks += 2;
      if (q_pix[v] !== ramp(1 + 16*v, 1, 16)) begin $display("FAIL bp_order[%0d] got=%h want=%h", v, q_pix[v], ramp(1 + 16*v, 1, 16)); failures++; end
      if (q_fd[v] !== (v == 2)) begin $display("FAIL bp_frame_done[%0d] got=%0b want=%0b", v, q_fd[v], v == 2); failures++; end
    end
  endtask

  task automatic test_mode_change();
    mode = 2'd1; out_ready = 1'b1; clear_q();
    for (int i = 1; i <= 32; i++) begin
      if (i == 20) mode = 2'd2;
      send(8'(i), i == 32);
    end
    for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
    idle(5);
    wait_vectors(3);
    if (q_pix.size() == 3) begin
      checks += 3;
      if (q_cast[0] !== 24'd0) begin $display("FAIL mc_cast0 got=%h want=0", q_cast[0]); failures++; end
      if (q_cast[1] !== {8'd16, 8'd15, 8'd14}) begin $display("FAIL mc_cast1 got=%h want=100f0e", q_cast[1]); failures++; end
      if (q_cast[2] !== {8'd3, 8'd2, 8'd1}) begin $display("FAIL mc_cast2 got=%h want=030201", q_cast[2]); failures++; end
    end
  endtask

  task automatic test_reset_mid_frame();
    mode = 2'd2; out_ready = 1'b1; clear_q();
    for (int i = 0; i < 7; i++) send(8'(8'hA0 + i), 1'b0);
    do_reset();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin $display("FAIL rm_out_valid got=%0b want=0", out_valid); failures++; end
    if (pix_now() !== 128'd0) begin $display("FAIL rm_pixel got=%h want=0", pix_now()); failures++; end
    if (in_ready !== 1'b1) begin $display("FAIL rm_in_ready got=%0b want=1", in_ready); failures++; end
    @(posedge clk); #1;
    mode = 2'd0;
    for (int i = 1; i <= 3; i++) send(8'(i + 50), i == 3);
    idle(5);
    wait_vectors(1);
    if (q_pix.size() == 1) begin
      checks += 2;
      if (q_pix[0] !== ramp(51, 1, 3)) begin $display("FAIL rm_fresh_pixel got=%h want=%h", q_pix[0], ramp(51, 1, 3)); failures++; end
      if (q_cast[0] !== 24'd0) begin $display("FAIL rm_fresh_cast got=%h want=0", q_cast[0]); failures++; end
    end
    clear_q();
    for (int i = 1; i <= 16; i++) send(8'(i + 100), i == 16);
    idle(5);
    wait_vectors(1);
    if (q_pix.size() == 1) begin
      checks++;
      if (q_pix[0] !== ramp(101, 1, 16)) begin $display("FAIL rm_full_pixel got=%h want=%h", q_pix[0], ramp(101, 1, 16)); failures++; end
    end
  endtask

  initial begin
    rst = 1'b1; mode = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_mode2_short();
    test_back_to_back();
    test_mode_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_row_pixel_feeder.md
Name: pe_row_pixel_feeder

Overview:
- Source-side driver for a 16-lane PE row.
- Accepts a serial 8-bit pixel stream over a valid/ready handshake and assembles it into 16-lane pixel vectors.
- Generates the 3-lane pixel_cast side vector according to mode, and presents each vector to the row through an output valid/ready handshake.
- Sits between the input activation buffer and the PE row.

Parameters:
- LANES, 16, pixels per output vector; lane 0 is the first pixel received.
- DW, 8, pixel width in bits.
- CAST, 3, number of pixel_cast lanes.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- mode  in  2  cast mode, sampled at frame start
- in_valid  in  1  input pixel valid
- in_ready  out  1  feeder can accept an input pixel
- in_data  in  DW  input pixel
- in_last  in  1  last pixel of frame, qualified by in_valid
- out_valid  out  1  pixel/pixel_cast vector valid
- out_ready  in  1  PE row consumes the vector
- pixel  out  DW x LANES (unpacked [LANES-1:0])  pixel vector
- pixel_cast  out  DW x CAST (unpacked [CAST-1:0])  cast vector
- frame_done  out  1  one-cycle pulse on the output handshake of a frame's last vector

Behaviour:
- Reset: out_valid=0, all pixel/pixel_cast lanes=0, frame_done=0, lane counter=0, staging and carry registers=0, state=FILL.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-frame discards all partial data.
- Two storage levels: a staging vector being filled, and an output register driving pixel/pixel_cast.
- State FILL:
  - in_ready=1.
  - Each accepted pixel (in_valid & in_ready) writes staging[lane_cnt], then lane_cnt++.
  - The first accepted pixel of a frame (lane_cnt=0 and first_of_frame) latches mode into mode_q.
  - Go to FULL when the pixel is accepted with lane_cnt=LANES-1 or with in_last=1.
  - On in_last, unfilled lanes are zero, record last_q=1, and lane_cnt returns to 0.
- State FULL:
  - in_ready=0.
  - Transfer staging to the output register when !out_valid | out_ready. Return to FILL in that cycle and clear staging.
  - Otherwise hold. Staging and output are never overwritten while valid.
- Latency: the pixel completing a vector is accepted in cycle t; out_valid=1 from cycle t+2 (t+1 FULL→transfer edge) if the output is free.
- Throughput: one bubble cycle per vector on the input side (in_ready=0 in the FULL cycle).
- Output handshake:
  - out_valid stays 1 and pixel/pixel_cast stay stable until out_ready=1.
  - The output register is updated only on transfer.
  - Simultaneous consume and transfer loads new data, and out_valid stays 1.
- pixel_cast, computed at transfer from mode_q:
  - mode 0: all cast lanes 0.
  - mode 1 (overlap): pixel_cast[k] = previous vector's lane LANES-CAST+k (lanes 13,14,15). This is zero for the first vector of a frame.
  - mode 2 (broadcast): pixel_cast[k] = current vector lane k.
  - mode 3: reserved, all cast lanes 0.
- Carry register: holds the last transferred vector's lanes 13..15. It is cleared when a vector with last_q=1 is transferred, so the next frame starts clean.
- frame_done=1 for exactly the cycle where out_valid & out_ready and the output vector carries last_q.
- Mode changes mid-frame are ignored until the next frame's first pixel.
- in_last on lane 15 closes the vector normally with no padding.
- in_last on lane 0 produces a vector with lanes 1..15 = 0.
- in_valid=0 pauses filling indefinitely; partial vectors are never emitted without in_last.

Test Plan:
1. mode=0: stream pixels 1..16 with in_last on 16, out_ready=1 → one vector with pixel[i]=i+1, pixel_cast={0,0,0}, frame_done pulses once, out_valid 2 cycles after the 16th accept.
2. mode=1: stream 1..32, last on 32 → vector0 cast={0,0,0}; vector1 pixel[0]=17, cast[0..2]={14,15,16}. Then a new frame of 1..16 → cast={0,0,0} (carry cleared).
3. mode=2: stream 5 pixels 10,20,30,40,50 with last → pixel[0..4]=10..50, pixel[5..15]=0, cast={10,20,30}, frame_done=1.
4. Backpressure: out_ready=0 while 48 pixels are offered → first vector held stable, second fills staging, in_ready=0 after the 32nd accept. Release out_ready → vectors emerge in order, none lost or duplicated.
5. Mode change mid-frame: mode=1 at pixel 1, switch to 2 at pixel 20 of a 32-pixel frame → vector1 cast={14,15,16}. The next frame uses mode 2.
6. Reset asserted after 7 pixels accepted → out_valid=0, outputs zero. Fresh 16-pixel frame afterward → correct vector with no stale lanes.
